// File: rtl/lockin_pkg.sv
// -----------------------------------------------------------------------------
// lockin_pkg
// Shared definitions for the lock-in phase sequencer: default channel count,
// default phase word width, the phase word type and the sequencer FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package lockin_pkg;

  localparam int NUM_CH  = 8;
  localparam int PHASE_W = 20;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lockin_shadow_bank.sv
// -----------------------------------------------------------------------------
// lockin_shadow_bank
// Holds the shadow copies of the per-channel phase increments and offsets that
// the sequencer actually uses, plus the "update pending" flag. New bus values
// are captured only when a frame is being started (tick accepted in IDLE) and
// an update has been requested, so a frame always runs on one consistent set.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   tick_accept  : a frame is being started this cycle
//   update_req   : request to load new incr/offs values at the next frame start
//   incr_bus     : per-channel increments, channel n at [n*PHASE_W +: PHASE_W]
//   offs_bus     : per-channel offsets, same packing
//   incr_sh      : shadowed increments, same packing
//   offs_sh      : shadowed offsets, same packing
// -----------------------------------------------------------------------------
module lockin_shadow_bank #(
  parameter int NUM_CH  = lockin_pkg::NUM_CH,
  parameter int PHASE_W = lockin_pkg::PHASE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_accept,
  input  logic                      update_req,
  input  logic [NUM_CH*PHASE_W-1:0] incr_bus,
  input  logic [NUM_CH*PHASE_W-1:0] offs_bus,
  output logic [NUM_CH*PHASE_W-1:0] incr_sh,
  output logic [NUM_CH*PHASE_W-1:0] offs_sh
);
  import lockin_pkg::*;

  logic pending;
  logic load;

  // A request arriving in the same cycle as the accepted tick counts as pending,
  // so that frame already runs on the new values.
  assign load = tick_accept && (pending || update_req);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      incr_sh <= '0;
      offs_sh <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        incr_sh <= incr_bus;
        offs_sh <= offs_bus;
      end
      pending <= tick_accept ? 1'b0 : (pending || update_req);
    end
  end

endmodule

// File: rtl/lockin_phase_sequencer.sv
// -----------------------------------------------------------------------------
// lockin_phase_sequencer
// On each accepted sample tick, steps through all lock-in channels, one per
// cycle: advances channel n's phase accumulator by its increment and emits the
// accumulator plus the channel offset (both wrap modulo 2^PHASE_W).
// Ticks arriving while a frame is in progress are dropped and set a sticky
// overrun flag.
//
// Optional feature: define LOCKIN_PHASE_CLEAR_EN to add the phase_clear input,
// which zeroes all accumulators at the next accepted tick (before the add).
//
// Ports
//   clk_clk        : clock, rising edge
//   reset_reset    : synchronous active-high reset
//   phase_incr_bus : per-channel increments, channel n at [n*PHASE_W +: PHASE_W]
//   phase_offs_bus : per-channel offsets, same packing
//   sample_tick    : one-cycle pulse, new ADC sample (frame start)
//   update_req     : pulse, load new incr/offs at the next frame start
//   phase_clear    : (LOCKIN_PHASE_CLEAR_EN only) clear accumulators at next frame
//   phase_out      : phase word for channel phase_ch
//   phase_ch       : channel index of phase_out
//   phase_valid    : phase_out/phase_ch valid this cycle
//   frame_done     : pulse with the last channel's phase_valid
//   busy           : frame in progress
//   overrun        : sticky, a tick arrived while busy
// -----------------------------------------------------------------------------
module lockin_phase_sequencer #(
  parameter  int NUM_CH  = lockin_pkg::NUM_CH,
  parameter  int PHASE_W = lockin_pkg::PHASE_W,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [NUM_CH*PHASE_W-1:0] phase_incr_bus,
  input  logic [NUM_CH*PHASE_W-1:0] phase_offs_bus,
  input  logic                      sample_tick,
  input  logic                      update_req,
`ifdef LOCKIN_PHASE_CLEAR_EN
  input  logic                      phase_clear,
`endif
  output logic [PHASE_W-1:0]        phase_out,
  output logic [CH_W-1:0]           phase_ch,
  output logic                      phase_valid,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      overrun
);
  import lockin_pkg::*;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                    state;
  logic [CH_W-1:0]           ch;
  logic [PHASE_W-1:0]        acc [NUM_CH];
  logic [NUM_CH*PHASE_W-1:0] incr_sh;
  logic [NUM_CH*PHASE_W-1:0] offs_sh;
  logic                      tick_accept;
  logic [PHASE_W-1:0]        incr_cur;
  logic [PHASE_W-1:0]        offs_cur;
  logic [PHASE_W-1:0]        acc_next;
  logic [PHASE_W-1:0]        phase_next;
`ifdef LOCKIN_PHASE_CLEAR_EN
  logic                      clear_pending;
`endif

  // Ticks are only honoured in IDLE; a tick in RUN is an overrun instead.
  assign tick_accept = (state == ST_IDLE) && sample_tick;

  lockin_shadow_bank #(
    .NUM_CH  (NUM_CH),
    .PHASE_W (PHASE_W)
  ) u_shadow (
    .clk         (clk_clk),
    .rst         (reset_reset),
    .tick_accept (tick_accept),
    .update_req  (update_req),
    .incr_bus    (phase_incr_bus),
    .offs_bus    (phase_offs_bus),
    .incr_sh     (incr_sh),
    .offs_sh     (offs_sh)
  );

  // Datapath for the channel being processed this cycle; additions wrap silently.
  assign incr_cur   = incr_sh[ch*PHASE_W +: PHASE_W];
  assign offs_cur   = offs_sh[ch*PHASE_W +: PHASE_W];
  assign acc_next   = acc[ch] + incr_cur;
  assign phase_next = acc_next + offs_cur;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= ST_IDLE;
      ch          <= '0;
      phase_out   <= '0;
      phase_ch    <= '0;
      phase_valid <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      // NOTE: the accumulator array is reset explicitly because the phase
      // sequence must restart from zero after reset; this keeps it in flops
      // rather than a RAM, which is fine at this channel count.
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
`ifdef LOCKIN_PHASE_CLEAR_EN
      clear_pending <= 1'b0;
`endif
    end else begin
      phase_valid <= 1'b0;
      frame_done  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            state <= ST_RUN;
            ch    <= '0;
            busy  <= 1'b1;
`ifdef LOCKIN_PHASE_CLEAR_EN
            // Zeroing here is equivalent to treating acc[] as 0 before the add.
            if (clear_pending || phase_clear) begin
              for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            end
`endif
          end
        end

        ST_RUN: begin
          if (sample_tick) overrun <= 1'b1;

          acc[ch]     <= acc_next;
          phase_out   <= phase_next;
          phase_ch    <= ch;
          phase_valid <= 1'b1;
          frame_done  <= (ch == LAST_CH);

          if (ch == LAST_CH) begin
            state <= ST_IDLE;
            ch    <= '0;
            busy  <= 1'b0;
          end else begin
            ch <= ch + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef LOCKIN_PHASE_CLEAR_EN
      clear_pending <= tick_accept ? 1'b0 : (clear_pending || phase_clear);
`endif
    end
  end

endmodule

// File: tb/tb_lockin_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lockin_phase_sequencer
// Scoreboard bench: each accepted tick pushes the expected per-channel phase
// words (with their expected output cycle) into a queue; a negedge monitor pops
// and compares whenever phase_valid is high. Directed scenarios add spot checks
// against hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lockin_phase_sequencer;
  import lockin_pkg::*;

  typedef struct {
    int     ch;
    phase_t ph;
    int     cyc;
  } exp_t;

  logic                      clk_clk = 1'b0;
  logic                      reset_reset;
  logic [NUM_CH*PHASE_W-1:0] incr_bus;
  logic [NUM_CH*PHASE_W-1:0] offs_bus;
  logic                      sample_tick;
  logic                      update_req;
`ifdef LOCKIN_PHASE_CLEAR_EN
  logic                      phase_clear;
`endif
  logic [PHASE_W-1:0]        phase_out;
  logic [$clog2(NUM_CH)-1:0] phase_ch;
  logic                      phase_valid;
  logic                      frame_done;
  logic                      busy;
  logic                      overrun;

  phase_t incr_v [NUM_CH];
  phase_t offs_v [NUM_CH];

  // Reference model state
  phase_t m_acc  [NUM_CH];
  phase_t m_incr [NUM_CH];
  phase_t m_offs [NUM_CH];
  bit     m_pend;
  bit     m_clr;

  exp_t   sb [$];
  phase_t last_ph [NUM_CH];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  lockin_phase_sequencer dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .phase_incr_bus (incr_bus),
    .phase_offs_bus (offs_bus),
    .sample_tick    (sample_tick),
    .update_req     (update_req),
`ifdef LOCKIN_PHASE_CLEAR_EN
    .phase_clear    (phase_clear),
`endif
    .phase_out      (phase_out),
    .phase_ch       (phase_ch),
    .phase_valid    (phase_valid),
    .frame_done     (frame_done),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  always_comb begin
    incr_bus = '0;
    offs_bus = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      incr_bus[n*PHASE_W +: PHASE_W] = incr_v[n];
      offs_bus[n*PHASE_W +: PHASE_W] = offs_v[n];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard.
  always @(negedge clk_clk) begin
    if (phase_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'd0, phase_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("phase_ch",   {29'd0, phase_ch}, e.ch);
        check("phase_out",  {12'd0, phase_out}, {12'd0, e.ph});
        check("valid_cycle", cyc, e.cyc);
        check("frame_done", {31'd0, frame_done}, (e.ch == NUM_CH - 1) ? 32'd1 : 32'd0);
        last_ph[e.ch] = phase_out;
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_clk);
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_acc[n]  = '0;
      m_incr[n] = '0;
      m_offs[n] = '0;
    end
    m_pend = 1'b0;
    m_clr  = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    model_reset();
    @(negedge clk_clk);
    reset_reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_phase_out"},   {12'd0, phase_out}, 32'd0);
    check({tag, "_phase_ch"},    {29'd0, phase_ch}, 32'd0);
    check({tag, "_phase_valid"}, {31'd0, phase_valid}, 32'd0);
    check({tag, "_frame_done"},  {31'd0, frame_done}, 32'd0);
    check({tag, "_busy"},        {31'd0, busy}, 32'd0);
    check({tag, "_overrun"},     {31'd0, overrun}, 32'd0);
  endtask

  // Drive a one-cycle tick from the current negedge. accept says whether the
  // bench expects the DUT to be idle; nvalid limits how many channel outputs
  // are expected (fewer when a reset cuts the frame short).
  task automatic tick(input bit accept, input bit upd, input bit clr, input int nvalid);
    int t;
    t = cyc;
    sample_tick = 1'b1;
    update_req  = upd;
`ifdef LOCKIN_PHASE_CLEAR_EN
    phase_clear = clr;
`endif
    if (accept) begin
      if (m_pend || upd) begin
        for (int n = 0; n < NUM_CH; n++) begin
          m_incr[n] = incr_v[n];
          m_offs[n] = offs_v[n];
        end
      end
      m_pend = 1'b0;
      if (m_clr || clr) for (int n = 0; n < NUM_CH; n++) m_acc[n] = '0;
      m_clr = 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        m_acc[n] = m_acc[n] + m_incr[n];
        if (n < nvalid) sb.push_back('{n, m_acc[n] + m_offs[n], t + 2 + n});
      end
    end else begin
      m_pend = m_pend || upd;
      m_clr  = m_clr || clr;
    end
    @(negedge clk_clk);
    sample_tick = 1'b0;
    update_req  = 1'b0;
`ifdef LOCKIN_PHASE_CLEAR_EN
    phase_clear = 1'b0;
`endif
  endtask

  // Full frame from IDLE with busy window checks; returns 20 cycles later.
  task automatic frame(input bit upd, input bit clr);
    int t;
    t = cyc;
    tick(1'b1, upd, clr, NUM_CH);
    check("busy_first", {31'd0, busy}, 32'd1);
    wait_until(t + NUM_CH);
    check("busy_last", {31'd0, busy}, 32'd1);
    wait_until(t + NUM_CH + 1);
    check("busy_done", {31'd0, busy}, 32'd0);
    wait_until(t + 20);
  endtask

  task automatic pulse_update();
    update_req = 1'b1;
    m_pend     = 1'b1;
    @(negedge clk_clk);
    update_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int k;
    for (int n = 0; n < NUM_CH; n++) begin
      incr_v[n]  = '0;
      offs_v[n]  = '0;
      last_ph[n] = '0;
    end
    model_reset();
    update_req  = 1'b0;
`ifdef LOCKIN_PHASE_CLEAR_EN
    phase_clear = 1'b0;
`endif
    // Reset with a coincident tick: the tick must be ignored.
    reset_reset = 1'b1;
    sample_tick = 1'b1;
    repeat (3) @(negedge clk_clk);
    check_zero("reset");
    reset_reset = 1'b0;
    sample_tick = 1'b0;
    repeat (4) @(negedge clk_clk);
    check("no_frame_after_reset_tick", {31'd0, busy}, 32'd0);

    // Load incr[n]=n+1, offs=0 with update+tick, then three frames.
    for (int n = 0; n < NUM_CH; n++) incr_v[n] = phase_t'(n + 1);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check("frame3_ch0", {12'd0, last_ph[0]}, 32'd3);
    check("frame3_ch7", {12'd0, last_ph[7]}, 32'd24);

    // Wrap: incr[0]=FFFFF, offs[0]=2.
    do_reset();
    check_zero("reset2");
    incr_v[0] = 20'hFFFFF;
    offs_v[0] = 20'h00002;
    frame(1'b1, 1'b0);
    check("wrap_frame1_ch0", {12'd0, last_ph[0]}, 32'h00001);
    frame(1'b0, 1'b0);
    check("wrap_frame2_ch0", {12'd0, last_ph[0]}, 32'h00000);

    // Overrun: tick at T+4 dropped, tick at T+9 accepted.
    check("overrun_clear_before", {31'd0, overrun}, 32'd0);
    t = cyc;
    tick(1'b1, 1'b0, 1'b0, NUM_CH);
    wait_until(t + 4);
    tick(1'b0, 1'b0, 1'b0, 0);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_until(t + 9);
    check("busy_low_at_T9", {31'd0, busy}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, NUM_CH);
    wait_until(t + 30);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Update during RUN: acc[2]=5, incr[2] 5->9 at T+3.
    do_reset();
    offs_v[0] = '0;
    incr_v[2] = 20'd5;
    frame(1'b1, 1'b0);
    check("upd_pre_ch2", {12'd0, last_ph[2]}, 32'd5);
    t = cyc;
    tick(1'b1, 1'b0, 1'b0, NUM_CH);
    wait_until(t + 3);
    incr_v[2] = 20'd9;
    pulse_update();
    wait_until(t + 20);
    check("upd_cur_ch2", {12'd0, last_ph[2]}, 32'd10);
    frame(1'b0, 1'b0);
    check("upd_next_ch2", {12'd0, last_ph[2]}, 32'd19);
    // Bus change without update_req must be ignored.
    incr_v[2] = 20'd100;
    frame(1'b0, 1'b0);
    check("bus_ignored_ch2", {12'd0, last_ph[2]}, 32'd28);

    // Reset mid-frame at T+5: only channels 0..3 appear.
    t = cyc;
    tick(1'b1, 1'b0, 1'b0, 4);
    wait_until(t + 5);
    do_reset();
    check_zero("midframe_reset");
    repeat (12) @(negedge clk_clk);
    frame(1'b0, 1'b0);
    check("post_reset_ch2", {12'd0, last_ph[2]}, 32'd0);
    check("post_reset_ch7", {12'd0, last_ph[7]}, 32'd0);

`ifdef LOCKIN_PHASE_CLEAR_EN
    // Phase clear: 3 frames with incr[1]=7, offs[1]=3, then clear+tick.
    do_reset();
    incr_v[1] = 20'd7;
    offs_v[1] = 20'd3;
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check("clr_pre_ch1", {12'd0, last_ph[1]}, 32'd24);
    frame(1'b0, 1'b1);
    check("clr_ch1", {12'd0, last_ph[1]}, 32'd10);
`endif

    // Drain the scoreboard with a bounded wait.
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk_clk);
      k++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
